// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the unified-memory arbiter.
// Imported by the arbiter, its picker and the bench.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    localparam int PORT_FETCH = 0;
    localparam int PORT_DATA  = 1;
    localparam int PORT_DBG   = 2;

    function automatic int rr_slot(input int base, input int off, input int n);
        return (base + off) % n;
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester and memory bus of the arbiter.
// master: the arbiter; slave: requesters plus memory.
interface mem_arbiter_if #(
    parameter int N_REQ  = 3,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [N_REQ-1:0]        req_valid;
    logic [N_REQ-1:0]        req_we;
    logic [N_REQ-1:0]        req_lock;
    logic [N_REQ*ADDR_W-1:0] req_addr;
    logic [N_REQ*DATA_W-1:0] req_wdata;
    logic [N_REQ-1:0]        req_ready;
    logic [N_REQ-1:0]        resp_valid;
    logic [DATA_W-1:0]       resp_rdata;
    logic                    resp_err;
    logic                    mem_valid;
    logic                    mem_we;
    logic [ADDR_W-1:0]       mem_addr;
    logic [DATA_W-1:0]       mem_wdata;
    logic                    mem_ready;
    logic [DATA_W-1:0]       mem_rdata;

    modport master (
        input  req_valid, req_we, req_lock, req_addr, req_wdata,
        input  mem_ready, mem_rdata,
        output req_ready, resp_valid, resp_rdata, resp_err,
        output mem_valid, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        output req_valid, req_we, req_lock, req_addr, req_wdata,
        output mem_ready, mem_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_err,
        input  mem_valid, mem_we, mem_addr, mem_wdata
    );

endinterface

// File: rtl/mem_arbiter_rr_pick.sv
// Combinational winner select: lock owner first,
// else round-robin scan starting after rr_ptr.
module mem_arbiter_rr_pick
    import mem_arbiter_pkg::*;
#(
    parameter int N_REQ = 3,
    parameter int IW    = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IW-1:0]    rr_ptr,
    input  logic             lock_valid,
    input  logic [IW-1:0]    lock_owner,
    output logic [N_REQ-1:0] grant,
    output logic [IW-1:0]    idx,
    output logic             any
);

    always_comb begin
        int j;
        j     = 0;
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        if (lock_valid && req[lock_owner]) begin
            grant[lock_owner] = 1'b1;
            idx               = lock_owner;
            any               = 1'b1;
        end else begin
            for (int i = 1; i <= N_REQ; i++) begin
                j = rr_slot(int'(rr_ptr), i, N_REQ);
                if (!any && req[j]) begin
                    grant[j] = 1'b1;
                    idx      = IW'(j);
                    any      = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory between N_REQ
// requesters, one access in flight, with lock and watchdog.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int N_REQ   = 3,
    parameter int TIMEOUT = 16,
    parameter int IW      = $clog2(N_REQ)
) (
    input  logic           clk,
    input  logic           reset,
    mem_arbiter_if.master  bus,
    output logic [IW-1:0]  grant_id,
    output logic           busy
);

    localparam int CW = $clog2(TIMEOUT);

    state_t              state, state_n;
    logic [IW-1:0]       rr_ptr;
    logic [IW-1:0]       lock_owner;
    logic                lock_valid;
    logic [CW-1:0]       cnt;
    logic [N_REQ-1:0]    win_oh;
    logic [IW-1:0]       win_idx;
    logic                win_any;
    logic [ADDR_W-1:0]   sel_addr;
    logic [DATA_W-1:0]   sel_wdata;
    logic                sel_we;
    logic                sel_lock;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic                we_q;
    logic [DATA_W-1:0]   rdata_q;
    logic                err_q;

    mem_arbiter_rr_pick #(.N_REQ(N_REQ)) u_rr_pick (
        .req        (bus.req_valid),
        .rr_ptr     (rr_ptr),
        .lock_valid (lock_valid),
        .lock_owner (lock_owner),
        .grant      (win_oh),
        .idx        (win_idx),
        .any        (win_any)
    );

    always_comb begin
        sel_addr  = '0;
        sel_wdata = '0;
        sel_we    = 1'b0;
        sel_lock  = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (win_oh[i]) begin
                sel_addr  = bus.req_addr[i*ADDR_W +: ADDR_W];
                sel_wdata = bus.req_wdata[i*DATA_W +: DATA_W];
                sel_we    = bus.req_we[i];
                sel_lock  = bus.req_lock[i];
            end
        end
    end

    always_comb begin
        state_n = state;
        unique case (state)
            ST_IDLE:   if (win_any) state_n = ST_ACCESS;
            ST_ACCESS: begin
                if (bus.mem_ready || cnt == CW'(TIMEOUT - 1))
                    state_n = ST_RESP;
            end
            ST_RESP:   state_n = ST_IDLE;
            default:   state_n = ST_IDLE;
        endcase
    end

    // Accept only in IDLE; an asserted reset masks the picker too.
    always_comb begin
        bus.req_ready = '0;
        bus.resp_valid = '0;
        if (state == ST_IDLE && reset)
            bus.req_ready = win_oh;
        for (int i = 0; i < N_REQ; i++)
            bus.resp_valid[i] = (state == ST_RESP) && (grant_id == IW'(i));
    end

    assign bus.mem_valid  = (state == ST_ACCESS);
    assign bus.mem_we     = we_q;
    assign bus.mem_addr   = addr_q;
    assign bus.mem_wdata  = wdata_q;
    assign bus.resp_rdata = rdata_q;
    assign bus.resp_err   = err_q;
    assign busy           = (state != ST_IDLE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= ST_IDLE;
            rr_ptr     <= IW'(N_REQ - 1);
            lock_owner <= '0;
            lock_valid <= 1'b0;
            cnt        <= '0;
            grant_id   <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            we_q       <= 1'b0;
            rdata_q    <= '0;
            err_q      <= 1'b0;
        end else begin
            state <= state_n;
            unique case (state)
                ST_IDLE: begin
                    cnt <= '0;
                    if (win_any) begin
                        addr_q     <= sel_addr;
                        wdata_q    <= sel_wdata;
                        we_q       <= sel_we;
                        grant_id   <= win_idx;
                        rr_ptr     <= win_idx;
                        lock_valid <= sel_lock;
                        lock_owner <= win_idx;
                    end else begin
                        lock_valid <= 1'b0;
                    end
                end
                ST_ACCESS: begin
                    if (bus.mem_ready) begin
                        rdata_q <= bus.mem_rdata;
                        err_q   <= 1'b0;
                        cnt     <= '0;
                    end else if (cnt == CW'(TIMEOUT - 1)) begin
                        rdata_q <= '0;
                        err_q   <= 1'b1;
                        cnt     <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: cnt <= '0;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: grants, lock,
// stalls, watchdog abort and async reset.
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    localparam int N  = 3;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 16;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] grant_id;
    logic       busy;

    mem_arbiter_if #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW)) bus ();

    mem_arbiter #(
        .ADDR_W(AW), .DATA_W(DW), .N_REQ(N), .TIMEOUT(TO)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus),
        .grant_id (grant_id),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int p, input logic we, input logic lk,
                           input logic [31:0] a, input logic [31:0] d);
        bus.req_valid[p]            = 1'b1;
        bus.req_we[p]               = we;
        bus.req_lock[p]             = lk;
        bus.req_addr[p*AW +: AW]    = a;
        bus.req_wdata[p*DW +: DW]   = d;
    endtask

    logic [2:0] e;
    int         acc;

    initial begin
        reset         = 1'b0;
        bus.req_valid = '0;
        bus.req_we    = '0;
        bus.req_lock  = '0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.mem_ready = 1'b0;
        bus.mem_rdata = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_mvalid", bus.mem_valid, 0);
        chk("rst_resp", bus.resp_valid, 0);
        chk("rst_gid", grant_id, 0);
        chk("rst_ready", bus.req_ready, 0);
        reset = 1'b1;
        step;

        // single data-port read
        set_req(PORT_DATA, 0, 0, 32'h4, 0);
        bus.mem_ready = 1'b1;
        bus.mem_rdata = 32'h8;
        #1;
        chk("t1_ready", bus.req_ready, 3'b010);
        step;
        bus.req_valid = '0;
        chk("t1_mvalid", bus.mem_valid, 1);
        chk("t1_addr", bus.mem_addr, 32'h4);
        chk("t1_gid", grant_id, 1);
        step;
        chk("t1_resp", bus.resp_valid, 3'b010);
        chk("t1_rdata", bus.resp_rdata, 32'h8);
        chk("t1_err", bus.resp_err, 0);
        chk("t1_mvalid_off", bus.mem_valid, 0);
        step;

        // all ports requesting after reset
        reset = 1'b0;
        step;
        reset = 1'b1;
        for (int p = 0; p < N; p++)
            set_req(p, 0, 0, 32'h20 + 32'(p * 4), 0);
        for (int t = 0; t < 6; t++) begin
            e = 3'b001 << (t % 3);
            bus.mem_rdata = 32'h100 + 32'(t);
            #1;
            chk("t2_ready", bus.req_ready, e);
            step;
            chk("t2_noready", bus.req_ready, 0);
            chk("t2_addr", bus.mem_addr, 32'h20 + 32'((t % 3) * 4));
            step;
            chk("t2_resp", bus.resp_valid, e);
            chk("t2_rdata", bus.resp_rdata, 32'h100 + 32'(t));
            step;
        end

        // port 2 locked three times against ports 0/1
        bus.req_valid = 3'b100;
        for (int n = 0; n < 3; n++) begin
            bus.req_lock = (n < 2) ? 3'b100 : 3'b000;
            #1;
            chk("t3_ready", bus.req_ready, 3'b100);
            step;
            if (n == 0) bus.req_valid = 3'b111;
            step;
            chk("t3_resp", bus.resp_valid, 3'b100);
            step;
        end
        #1;
        chk("t3_after", bus.req_ready, 3'b001);
        bus.req_valid = '0;
        bus.req_lock  = '0;
        step;

        // stalled write
        bus.mem_ready = 1'b0;
        set_req(PORT_DATA, 1, 0, 32'h10, 32'hDEADBEEF);
        #1;
        chk("t4_ready", bus.req_ready, 3'b010);
        step;
        bus.req_valid = '0;
        for (int i = 0; i < 6; i++) begin
            chk("t4_mvalid", bus.mem_valid, 1);
            chk("t4_addr", bus.mem_addr, 32'h10);
            chk("t4_wdata", bus.mem_wdata, 32'hDEADBEEF);
            chk("t4_we", bus.mem_we, 1);
            if (i == 5) bus.mem_ready = 1'b1;
            step;
        end
        chk("t4_resp", bus.resp_valid, 3'b010);
        chk("t4_err", bus.resp_err, 0);
        bus.mem_ready = 1'b0;
        step;

        // watchdog abort
        set_req(PORT_FETCH, 0, 0, 32'h30, 0);
        #1;
        chk("t5_ready", bus.req_ready, 3'b001);
        step;
        bus.req_valid = '0;
        acc = 0;
        for (int c = 0; c < 40 && bus.mem_valid; c++) begin
            acc++;
            step;
        end
        chk("t5_cycles", acc, TO);
        chk("t5_resp", bus.resp_valid, 3'b001);
        chk("t5_err", bus.resp_err, 1);
        chk("t5_rdata", bus.resp_rdata, 0);
        step;
        set_req(PORT_DBG, 0, 0, 32'h40, 0);
        bus.mem_ready = 1'b1;
        bus.mem_rdata = 32'h55;
        #1;
        chk("t5_next_ready", bus.req_ready, 3'b100);
        step;
        bus.req_valid = '0;
        step;
        chk("t5_next_resp", bus.resp_valid, 3'b100);
        chk("t5_next_err", bus.resp_err, 0);
        chk("t5_next_rdata", bus.resp_rdata, 32'h55);
        step;

        // async reset during access
        bus.mem_ready = 1'b0;
        set_req(PORT_DATA, 0, 0, 32'h50, 0);
        #1;
        chk("t6_ready", bus.req_ready, 3'b010);
        step;
        bus.req_valid = '0;
        chk("t6_mvalid", bus.mem_valid, 1);
        chk("t6_busy", busy, 1);
        #2;
        reset = 1'b0;
        #1;
        chk("t6_mvalid_rst", bus.mem_valid, 0);
        chk("t6_busy_rst", busy, 0);
        chk("t6_resp_rst", bus.resp_valid, 0);
        @(negedge clk);
        reset = 1'b1;
        bus.req_valid = 3'b111;
        #1;
        chk("t6_first", bus.req_ready, 3'b001);
        bus.req_valid = '0;
        step;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
